// File: rtl/aes_pkg.sv
// Shared AES types, the S-box and the byte-level round transforms.
// State layout: byte i of the block sits at bits [127-8*i -: 8], so byte 0
// is the most significant byte. Column c holds bytes 4c..4c+3, and row 0 of
// each column is its most significant byte.
package aes_pkg;

    typedef logic [127:0] aes_128;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ROUND = 2'b01,
        DONE  = 2'b10
    } aes_enc_state_e;

    // Forward S-box. Entry 0 is stored in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b lives (255-b) bytes up from bit 0; ~b is exactly 255-b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic aes_128 sub_bytes(input aes_128 s);
        aes_128 r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    // Row r of the output takes row r of column (c+r) mod 4.
    function automatic aes_128 shift_rows(input aes_128 s);
        aes_128 r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
            end
        end
        return r;
    endfunction

    // Round count for a key length; 0 flags an illegal length.
    function automatic logic [3:0] nr_of(input int key_len);
        case (key_len)
            128:     return 4'd10;
            192:     return 4'd12;
            256:     return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// MixColumns over all four columns of the state.
module aes_mix_column
    import aes_pkg::*;
(
    input  aes_128 i_state,
    output aes_128 o_state
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Mix each 32-bit column independently.
    always_comb begin
        o_state = '0;
        for (int c = 0; c < 4; c++) begin
            o_state[127-32*c -: 32] = mix_col(i_state[127-32*c -: 32]);
        end
    end

endmodule

// File: rtl/aes_round_dp.sv
// One combinational AES encryption round; MixColumns is bypassed on the final round.
module aes_round_dp
    import aes_pkg::*;
(
    input  aes_128 i_state,
    input  aes_128 i_round_key,
    input  logic   i_final,
    output aes_128 o_state
);

    aes_128 w_sr;
    aes_128 w_mc;

    assign w_sr = shift_rows(sub_bytes(i_state));

    aes_mix_column u_mix (
        .i_state (w_sr),
        .o_state (w_mc)
    );

    // Pick the final-round or full-round result, then add the round key.
    always_comb begin
        if (i_final) begin
            o_state = w_sr ^ i_round_key;
        end else begin
            o_state = w_mc ^ i_round_key;
        end
    end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES encryptor: one round per cycle over a shared round datapath,
// with valid/ready on both sides and a round-key index for the key store.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 128
)(
    input  logic   clk,
    input  logic   nrst,
    input  logic   flush_i,
    input  logic   in_valid_i,
    output logic   in_ready_o,
    input  aes_128 plain_text_i,
    output logic [3:0] rnd_idx_o,
    input  aes_128 rnd_key_i,
    output logic   out_valid_o,
    input  logic   out_ready_i,
    output aes_128 cipher_o
);

    localparam logic [3:0] NR = nr_of(KEY_LEN);

    if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
        $error("aes_enc_iter: KEY_LEN must be 128, 192 or 256");
    end

    aes_enc_state_e r_fsm;
    aes_enc_state_e w_fsm_nxt;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_nxt;
    aes_128         r_data;
    aes_128         w_data_nxt;
    aes_128         w_round;
    logic           w_final;
    logic           w_in_ready;

    assign w_final = (r_cnt == NR);

    aes_round_dp u_round (
        .i_state     (r_data),
        .i_round_key (rnd_key_i),
        .i_final     (w_final),
        .o_state     (w_round)
    );

    // Next-state logic. The counter returns to 0 on entering DONE so that it
    // can drive the round-key index directly in every state.
    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_cnt_nxt  = r_cnt;
        w_data_nxt = r_data;
        w_in_ready = 1'b0;
        if (flush_i) begin
            w_fsm_nxt  = IDLE;
            w_cnt_nxt  = 4'd0;
            w_data_nxt = '0;
            w_in_ready = (r_fsm == IDLE) ? 1'b1 :
                         (r_fsm == DONE) ? out_ready_i : 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    w_in_ready = 1'b1;
                    if (in_valid_i) begin
                        w_data_nxt = plain_text_i ^ rnd_key_i;
                        w_cnt_nxt  = 4'd1;
                        w_fsm_nxt  = ROUND;
                    end else begin
                        w_fsm_nxt  = IDLE;
                    end
                end
                ROUND: begin
                    w_data_nxt = w_round;
                    if (w_final) begin
                        w_cnt_nxt = 4'd0;
                        w_fsm_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    w_in_ready = out_ready_i;
                    if (out_ready_i && in_valid_i) begin
                        w_data_nxt = plain_text_i ^ rnd_key_i;
                        w_cnt_nxt  = 4'd1;
                        w_fsm_nxt  = ROUND;
                    end else if (out_ready_i) begin
                        w_fsm_nxt  = IDLE;
                    end else begin
                        w_fsm_nxt  = DONE;
                    end
                end
                default: begin
                    w_fsm_nxt  = IDLE;
                    w_cnt_nxt  = 4'd0;
                    w_data_nxt = '0;
                end
            endcase
        end
    end

    // FSM, round counter and cipher state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_fsm  <= IDLE;
            r_cnt  <= 4'd0;
            r_data <= '0;
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_cnt  <= w_cnt_nxt;
            r_data <= w_data_nxt;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = (r_fsm == DONE);
    assign rnd_idx_o   = r_cnt;
    assign cipher_o    = r_data;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed-vector bench for aes_enc_iter at all three key lengths.
module tb_aes_enc_iter;
    import aes_pkg::*;

    localparam aes_128 PT   = 128'h00112233445566778899aabbccddeeff;
    localparam aes_128 C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_128 C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam aes_128 C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic       clk = 1'b0;
    logic       nrst;
    logic       flush;
    logic       ordy;
    aes_128     pt;
    logic       iv  [0:2];
    logic       ir  [0:2];
    logic       ov  [0:2];
    logic [3:0] idx [0:2];
    aes_128     ct  [0:2];
    aes_128     key [0:2];

    aes_128      rk128 [0:10];
    aes_128      rk192 [0:12];
    aes_128      rk256 [0:14];
    logic [31:0] w     [0:59];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign key[0] = (idx[0] <= 4'd10) ? rk128[idx[0]] : '0;
    assign key[1] = (idx[1] <= 4'd12) ? rk192[idx[1]] : '0;
    assign key[2] = (idx[2] <= 4'd14) ? rk256[idx[2]] : '0;

    aes_enc_iter #(.KEY_LEN(128)) u_dut128 (
        .clk(clk), .nrst(nrst), .flush_i(flush), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .plain_text_i(pt), .rnd_idx_o(idx[0]), .rnd_key_i(key[0]), .out_valid_o(ov[0]),
        .out_ready_i(ordy), .cipher_o(ct[0]));
    aes_enc_iter #(.KEY_LEN(192)) u_dut192 (
        .clk(clk), .nrst(nrst), .flush_i(flush), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .plain_text_i(pt), .rnd_idx_o(idx[1]), .rnd_key_i(key[1]), .out_valid_o(ov[1]),
        .out_ready_i(ordy), .cipher_o(ct[1]));
    aes_enc_iter #(.KEY_LEN(256)) u_dut256 (
        .clk(clk), .nrst(nrst), .flush_i(flush), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
        .plain_text_i(pt), .rnd_idx_o(idx[2]), .rnd_key_i(key[2]), .out_valid_o(ov[2]),
        .out_ready_i(ordy), .cipher_o(ct[2]));

    task automatic check_eq(input string tag, input aes_128 got, input aes_128 exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    // FIPS-197 key expansion; key is left-aligned in 256 bits.
    task automatic expand(input logic [255:0] k, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    task automatic encrypt(input int k, input aes_128 exp, input int nr, input string tag);
        int c;
        pt    = PT;
        iv[k] = 1'b1;
        check_eq({tag, "_rdy"}, 128'(ir[k]), 128'd1);
        tick();
        iv[k] = 1'b0;
        c = 0;
        while (!ov[k] && c < 40) begin
            tick();
            c++;
        end
        check_eq({tag, "_latency"}, 128'(c), 128'(nr));
        check_eq({tag, "_cipher"}, ct[k], exp);
        tick();
        check_eq({tag, "_valid_drop"}, 128'(ov[k]), 128'd0);
    endtask

    task automatic wait_idx(input logic [3:0] v, input string tag);
        int c;
        c = 0;
        while (idx[0] != v && c < 20) begin
            tick();
            c++;
        end
        check_eq(tag, 128'(idx[0] == v), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int n_done;
        int t_done [0:2];
        aes_128 c_done [0:2];

        nrst  = 1'b0;
        flush = 1'b0;
        ordy  = 1'b1;
        pt    = '0;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;

        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        for (int r = 0; r <= 10; r++) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
        for (int r = 0; r <= 12; r++) rk192[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        for (int r = 0; r <= 14; r++) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        // Reset values
        #12;
        check_eq("rst_in_ready",  128'(ir[0]),  128'd1);
        check_eq("rst_out_valid", 128'(ov[0]),  128'd0);
        check_eq("rst_rnd_idx",   128'(idx[0]), 128'd0);
        check_eq("rst_cipher",    ct[0],        128'd0);
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // FIPS vectors for all key lengths
        encrypt(0, C128, 10, "k128");
        encrypt(1, C192, 12, "k192");
        encrypt(2, C256, 14, "k256");

        // Backpressure: hold the result for 5 cycles with a competing input
        ordy  = 1'b0;
        pt    = PT;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        c = 0;
        while (!ov[0] && c < 40) begin
            tick();
            c++;
        end
        check_eq("bp_latency", 128'(c), 128'd10);
        pt    = ~PT;
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid_hold", 128'(ov[0]), 128'd1);
            check_eq("bp_cipher_hold", ct[0], C128);
            check_eq("bp_in_ready", 128'(ir[0]), 128'd0);
        end
        iv[0] = 1'b0;
        ordy  = 1'b1;
        #1;
        check_eq("bp_ready_follow", 128'(ir[0]), 128'd1);
        tick();
        check_eq("bp_release_valid", 128'(ov[0]), 128'd0);
        check_eq("bp_release_idle", 128'(ir[0]), 128'd1);

        // Back-to-back: three blocks with in_valid held high
        pt     = PT;
        iv[0]  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            t_done[i] = 0;
            c_done[i] = '0;
        end
        tick();
        c = 0;
        while (n_done < 3 && c < 60) begin
            tick();
            c++;
            if (ov[0]) begin
                t_done[n_done] = c;
                c_done[n_done] = ct[0];
                n_done++;
                if (n_done == 3) iv[0] = 1'b0;
            end
        end
        iv[0] = 1'b0;
        check_eq("b2b_count", 128'(n_done), 128'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("b2b_time", 128'(t_done[i]), 128'(10 + 11*i));
            check_eq("b2b_cipher", c_done[i], C128);
        end
        tick();
        check_eq("b2b_end_valid", 128'(ov[0]), 128'd0);
        check_eq("b2b_end_idle", 128'(ir[0]), 128'd1);

        // Flush at counter 5
        pt    = PT;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        wait_idx(4'd5, "flush_reach_cnt5");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_valid",  128'(ov[0]),  128'd0);
        check_eq("flush_cipher", ct[0],        128'd0);
        check_eq("flush_idle",   128'(ir[0]),  128'd1);
        check_eq("flush_idx",    128'(idx[0]), 128'd0);
        encrypt(0, C128, 10, "post_flush");

        // Asynchronous reset pulse at counter 3
        pt    = PT;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        wait_idx(4'd3, "rst_reach_cnt3");
        #2;
        nrst = 1'b0;
        #1;
        check_eq("arst_in_ready",  128'(ir[0]),  128'd1);
        check_eq("arst_out_valid", 128'(ov[0]),  128'd0);
        check_eq("arst_rnd_idx",   128'(idx[0]), 128'd0);
        check_eq("arst_cipher",    ct[0],        128'd0);
        @(negedge clk);
        nrst = 1'b1;
        c = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (ov[0]) c++;
        end
        check_eq("arst_no_valid", 128'(c), 128'd0);
        encrypt(0, C128, 10, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
